// File: rtl/proc_pkg.sv
// Shared encodings for the processor MMIO slice: bus region select and
// run-control FSM states.
package proc_pkg;

  // Region a processor address decodes to; NONE marks unmapped space.
  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_RAM  = 2'd1,
    SEL_IO   = 2'd2
  } sel_t;

  // Run-control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/sync_ram.sv
// Single-port synchronous RAM with a registered read port. The read samples
// the array before the same-edge write lands, so a read of the address being
// written returns the previous contents. Contents are never reset.
module sync_ram #(
  parameter int DATA_W = 16,
  parameter int RAM_AW = 6
) (
  input  logic              clk,
  input  logic              we,
  input  logic [RAM_AW-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_r [2**RAM_AW];

  // Array write and registered read-before-write data path.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
    rdata <= mem_r[addr];
  end

endmodule

// File: rtl/ram_proc_mmio.sv
// Processor-side memory system: address decode into RAM / output-register
// window / unmapped space, one-cycle read mux, sticky bus-error flag, and a
// run-control FSM that counts the cycles spent in RUN.
module ram_proc_mmio import proc_pkg::*; #(
  parameter int                DATA_W  = 16,
  parameter int                ADDR_W  = 16,
  parameter int                RAM_AW  = 6,
  parameter int                N_OUT   = 4,
  parameter logic [ADDR_W-1:0] IO_BASE = 16'h1000,
  parameter int                CNT_W   = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    run,
  input  logic [ADDR_W-1:0]       procAddr,
  input  logic [DATA_W-1:0]       procDout,
  input  logic                    procW,
  input  logic                    procDone,
  output logic [DATA_W-1:0]       procDin,
  output logic                    done,
  output logic [CNT_W-1:0]        cycles,
  output logic [N_OUT*DATA_W-1:0] outRegs,
  output logic                    busErr
);

  localparam int                IDX_W   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  // Compares are done one bit wider so the window ends cannot overflow.
  localparam logic [ADDR_W:0]   RAM_END = (ADDR_W + 1)'(2 ** RAM_AW);
  localparam logic [ADDR_W:0]   IO_END  = {1'b0, IO_BASE} + (ADDR_W + 1)'(N_OUT);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  sel_t              sel_s;
  sel_t              sel_r;
  logic [IDX_W-1:0]  io_idx_s;
  logic              ram_we_s;
  logic [DATA_W-1:0] ram_q_s;
  logic [DATA_W-1:0] io_rd_r;
  logic [DATA_W-1:0] out_regs_r [N_OUT];
  logic              bus_err_r;
  state_t            state_r;
  state_t            state_n_s;
  logic              done_r;
  logic [CNT_W-1:0]  cycles_r;

  // Address decode; RAM wins if the IO window were ever placed over it.
  always_comb begin
    sel_s    = SEL_NONE;
    io_idx_s = IDX_W'(procAddr - IO_BASE);
    if ({1'b0, procAddr} < RAM_END) begin
      sel_s = SEL_RAM;
    end else if ((procAddr >= IO_BASE) && ({1'b0, procAddr} < IO_END)) begin
      sel_s = SEL_IO;
    end else begin
      sel_s = SEL_NONE;
    end
  end

  // RAM write enable, held off while reset is asserted.
  always_comb begin
    ram_we_s = 1'b0;
    if (procW && (sel_s == SEL_RAM) && !reset) begin
      ram_we_s = 1'b1;
    end else begin
      ram_we_s = 1'b0;
    end
  end

  sync_ram #(
    .DATA_W (DATA_W),
    .RAM_AW (RAM_AW)
  ) u_ram (
    .clk   (clock),
    .we    (ram_we_s),
    .addr  (procAddr[RAM_AW-1:0]),
    .wdata (procDout),
    .rdata (ram_q_s)
  );

  // Output-register file: cleared by reset, loaded by IO-window writes.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < N_OUT; k++) begin
        out_regs_r[k] <= {DATA_W{1'b0}};
      end
    end else if (procW && (sel_s == SEL_IO)) begin
      out_regs_r[io_idx_s] <= procDout;
    end
  end

  // Region select and IO read data registered together with the RAM read,
  // so the mux below stays aligned and IO reads see pre-write values.
  always_ff @(posedge clock) begin
    if (reset) begin
      sel_r   <= SEL_NONE;
      io_rd_r <= {DATA_W{1'b0}};
    end else begin
      sel_r   <= sel_s;
      io_rd_r <= out_regs_r[io_idx_s];
    end
  end

  // Read-data mux; unmapped reads return zero.
  always_comb begin
    procDin = {DATA_W{1'b0}};
    case (sel_r)
      SEL_RAM: procDin = ram_q_s;
      SEL_IO:  procDin = io_rd_r;
      default: procDin = {DATA_W{1'b0}};
    endcase
  end

  // Sticky bus error: any cycle presenting an unmapped address sets it.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus_err_r <= 1'b0;
    end else if (sel_s == SEL_NONE) begin
      bus_err_r <= 1'b1;
    end
  end

  // FSM next state; run takes priority over procDone while idle.
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (run) state_n_s = ST_RUN;
        else     state_n_s = ST_IDLE;
      end
      ST_RUN: begin
        if (procDone) state_n_s = ST_DONE;
        else          state_n_s = ST_RUN;
      end
      ST_DONE: begin
        if (!run) state_n_s = ST_IDLE;
        else      state_n_s = ST_DONE;
      end
      default: state_n_s = ST_IDLE;
    endcase
  end

  // FSM state and registered done flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_n_s;
      done_r  <= (state_n_s == ST_DONE);
    end
  end

  // Run-cycle counter: cleared on entry to RUN, saturating count while in RUN.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycles_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_IDLE) && (state_n_s == ST_RUN)) begin
      cycles_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_RUN) && (cycles_r != CNT_MAX)) begin
      cycles_r <= cycles_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    assign outRegs[k*DATA_W +: DATA_W] = out_regs_r[k];
  end

  assign done   = done_r;
  assign cycles = cycles_r;
  assign busErr = bus_err_r;

endmodule

// File: tb/tb_ram_proc_mmio.sv
// Directed bench for ram_proc_mmio: expected read data is queued when an
// address is presented and compared when procDin is due one cycle later.
module tb_ram_proc_mmio;

  localparam logic [15:0] IOB = 16'h1000;

  logic        clock = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] procAddr;
  logic [15:0] procDout;
  logic        procW;
  logic        procDone;

  logic [15:0] procDin;
  logic        done;
  logic [31:0] cycles;
  logic [63:0] outRegs;
  logic        busErr;

  logic [15:0] procDin4;
  logic        done4;
  logic [3:0]  cycles4;
  logic [63:0] outRegs4;
  logic        busErr4;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  string       tag_q[$];

  always #5 clock = ~clock;

  ram_proc_mmio dut (
    .clock(clock), .reset(reset), .run(run), .procAddr(procAddr),
    .procDout(procDout), .procW(procW), .procDone(procDone),
    .procDin(procDin), .done(done), .cycles(cycles),
    .outRegs(outRegs), .busErr(busErr)
  );

  ram_proc_mmio #(.CNT_W(4)) dut4 (
    .clock(clock), .reset(reset), .run(run), .procAddr(procAddr),
    .procDout(procDout), .procW(procW), .procDone(procDone),
    .procDin(procDin4), .done(done4), .cycles(cycles4),
    .outRegs(outRegs4), .busErr(busErr4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // One bus cycle; a queued read expectation is checked after the edge.
  task automatic bus(input logic [15:0] a, input logic w, input logic [15:0] d,
                     input logic chk, input logic [15:0] exp, input string tag);
    procAddr = a;
    procW    = w;
    procDout = d;
    if (chk) begin
      exp_q.push_back(exp);
      tag_q.push_back(tag);
    end
    @(posedge clock);
    #1;
    procW    = 1'b0;
    procAddr = 16'h0000;
    if (exp_q.size() > 0) begin
      check(tag_q.pop_front(), {48'h0, procDin}, {48'h0, exp_q.pop_front()});
    end
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; procDone = 1'b0;
    procAddr = 16'h0000; procDout = 16'h0000; procW = 1'b0;
    tick(2);
    check("rst_done",    {63'h0, done},    64'h0);
    check("rst_cycles",  {32'h0, cycles},  64'h0);
    check("rst_outregs", outRegs,          64'h0);
    check("rst_buserr",  {63'h0, busErr},  64'h0);
    check("rst_procdin", {48'h0, procDin}, 64'h0);
    reset = 1'b0;

    // Writes while reset is high must not land; RAM survives reset.
    bus(16'd7, 1'b1, 16'h1111, 1'b0, 16'h0, "");
    reset = 1'b1;
    bus(16'd7, 1'b1, 16'hDEAD, 1'b1, 16'h0000, "rst_read_zero");
    bus(IOB + 16'd1, 1'b1, 16'hAAAA, 1'b0, 16'h0, "");
    reset = 1'b0;
    check("rst_io_suppressed", outRegs, 64'h0);
    bus(16'd7, 1'b0, 16'h0, 1'b1, 16'h1111, "ram_kept_no_rst_write");

    // RAM write/read and read-before-write.
    bus(16'd5, 1'b1, 16'h00AB, 1'b0, 16'h0, "");
    bus(16'd5, 1'b0, 16'h0, 1'b1, 16'h00AB, "ram_rd5");
    bus(16'd5, 1'b1, 16'h5555, 1'b1, 16'h00AB, "ram_rbw");
    bus(16'd5, 1'b0, 16'h0, 1'b1, 16'h5555, "ram_rd5_new");
    bus(16'd6, 1'b1, 16'h0C0C, 1'b0, 16'h0, "");
    bus(16'd63, 1'b1, 16'h3F3F, 1'b0, 16'h0, "");
    bus(16'd0, 1'b1, 16'h0A0A, 1'b0, 16'h0, "");
    bus(16'd6, 1'b0, 16'h0, 1'b1, 16'h0C0C, "ram_rd6");
    bus(16'd63, 1'b0, 16'h0, 1'b1, 16'h3F3F, "ram_rd_top");
    bus(16'd5, 1'b0, 16'h0, 1'b1, 16'h5555, "ram_rd5_again");

    // Output-register window.
    bus(IOB + 16'd2, 1'b1, 16'h1234, 1'b0, 16'h0, "");
    check("io_slot2", outRegs, 64'h0000_1234_0000_0000);
    bus(IOB + 16'd2, 1'b0, 16'h0, 1'b1, 16'h1234, "io_rd2");
    bus(IOB + 16'd2, 1'b1, 16'hBEEF, 1'b1, 16'h1234, "io_rbw");
    bus(IOB + 16'd0, 1'b1, 16'h0001, 1'b0, 16'h0, "");
    bus(IOB + 16'd3, 1'b1, 16'hFFFF, 1'b0, 16'h0, "");
    check("io_all", outRegs, 64'hFFFF_BEEF_0000_0001);
    bus(IOB + 16'd0, 1'b0, 16'h0, 1'b1, 16'h0001, "io_rd0");
    bus(IOB + 16'd3, 1'b0, 16'h0, 1'b1, 16'hFFFF, "io_rd3");
    check("no_buserr_yet", {63'h0, busErr}, 64'h0);

    // Unmapped accesses: zero read data, sticky error, no storage change.
    bus(16'h0800, 1'b1, 16'h7777, 1'b1, 16'h0000, "unmapped_rd");
    check("buserr_set", {63'h0, busErr}, 64'h1);
    check("unmapped_io_same", outRegs, 64'hFFFF_BEEF_0000_0001);
    bus(16'd0, 1'b0, 16'h0, 1'b1, 16'h0A0A, "unmapped_ram_same");
    bus(16'd64, 1'b0, 16'h0, 1'b1, 16'h0000, "ram_end_unmapped");
    bus(IOB + 16'd4, 1'b1, 16'h9999, 1'b1, 16'h0000, "io_end_unmapped");
    bus(IOB - 16'd1, 1'b1, 16'h9999, 1'b1, 16'h0000, "io_below_unmapped");
    check("unmapped_io_same2", outRegs, 64'hFFFF_BEEF_0000_0001);
    tick(3);
    check("buserr_sticky", {63'h0, busErr}, 64'h1);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("buserr_cleared", {63'h0, busErr}, 64'h0);
    check("outregs_cleared", outRegs, 64'h0);

    // Run: pulse run, procDone sampled on the 11th edge in RUN.
    run = 1'b1;
    tick(1);
    check("run_enter_cycles", {32'h0, cycles}, 64'd0);
    run = 1'b0;
    tick(10);
    check("run_cycles10", {32'h0, cycles}, 64'd10);
    check("run_not_done", {63'h0, done}, 64'h0);
    procDone = 1'b1;
    tick(1);
    procDone = 1'b0;
    check("done_set", {63'h0, done}, 64'h1);
    check("done_cycles11", {32'h0, cycles}, 64'd11);
    check("cnt4_no_sat", {60'h0, cycles4}, 64'd11);
    tick(1);
    check("back_idle", {63'h0, done}, 64'h0);
    tick(3);
    check("idle_hold11", {32'h0, cycles}, 64'd11);

    // run and procDone together in IDLE: procDone ignored.
    run = 1'b1; procDone = 1'b1;
    tick(1);
    check("both_goes_run", {63'h0, done}, 64'h0);
    check("both_clear", {32'h0, cycles}, 64'd0);
    run = 1'b0;
    tick(1);
    check("both_then_done", {63'h0, done}, 64'h1);
    check("both_cycles1", {32'h0, cycles}, 64'd1);
    run = 1'b1; procDone = 1'b0;
    tick(1);
    check("done_held_run1", {63'h0, done}, 64'h1);
    run = 1'b0;
    tick(1);
    check("done_leave", {63'h0, done}, 64'h0);

    // Saturation on the 4-bit instance, then reset mid-run.
    bus(IOB + 16'd1, 1'b1, 16'h5A5A, 1'b0, 16'h0, "");
    run = 1'b1;
    tick(1);
    run = 1'b0;
    tick(20);
    check("cnt32_20", {32'h0, cycles}, 64'd20);
    check("cnt4_sat", {60'h0, cycles4}, 64'd15);
    check("sat_not_done", {63'h0, done4}, 64'h0);
    check("io_before_abort", outRegs, 64'h0000_0000_5A5A_0000);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("abort_done", {63'h0, done}, 64'h0);
    check("abort_cycles", {32'h0, cycles}, 64'd0);
    check("abort_cycles4", {60'h0, cycles4}, 64'd0);
    check("abort_outregs", outRegs, 64'h0);
    tick(3);
    check("abort_stays_idle", {32'h0, cycles}, 64'd0);
    bus(16'd5, 1'b0, 16'h0, 1'b1, 16'h5555, "ram_after_abort");
    bus(16'd7, 1'b0, 16'h0, 1'b1, 16'h1111, "ram7_after_abort");
    check("buserr4_clear", {63'h0, busErr4}, 64'h0);
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
